// File: rtl/rob_multi_commit_pkg.sv
// Shared CPU configuration for the reorder buffer: register index width and ROB tag type.
package rob_multi_commit_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int ROB_DEPTH_CFG = 16;
    localparam int ROB_TAG_W     = $clog2(ROB_DEPTH_CFG);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Prefix retire selection: walks entries head..head+CW-1 and stops at the first one not ready.
module rob_commit_sel #(
    parameter int DEPTH = 16,
    parameter int CW    = 2,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] done_i,
    input  logic [DEPTH-1:0] exc_i,
    input  logic [TAG_W-1:0] head_i,
    output logic [CW-1:0]    commit_mask_o,
    output logic [TAG_W:0]   retire_cnt_o,
    output logic             head_exc_o
);

    logic             run;
    logic [TAG_W-1:0] idx;

    always_comb begin
        commit_mask_o = '0;
        retire_cnt_o  = '0;
        run           = 1'b1;
        idx           = head_i;
        for (int i = 0; i < CW; i++) begin
            idx              = head_i + TAG_W'(i);
            // Once one slot is blocked, every later slot stays blocked: no gaps.
            run              = run & valid_i[idx] & done_i[idx] & ~exc_i[idx];
            commit_mask_o[i] = run;
            retire_cnt_o     = retire_cnt_o + {{TAG_W{1'b0}}, run};
        end
    end

    assign head_exc_o = valid_i[head_i] & done_i[head_i] & exc_i[head_i];

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with single allocate, single writeback and up to COMMIT_WIDTH in-order retirements.
module rob_multi_commit
    import rob_multi_commit_pkg::*;
#(
    parameter int DATA         = 32,
    parameter int ADDR         = 32,
    parameter int ROB_DEPTH    = ROB_DEPTH_CFG,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [ADDR-1:0]                   alloc_pc,
    input  reg_idx_t                          alloc_rd,
    output logic [$clog2(ROB_DEPTH)-1:0]      alloc_tag,
    input  logic                              wb_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0]      wb_tag,
    input  logic [DATA-1:0]                   wb_data,
    input  logic                              wb_exc,
    input  logic                              flush_in,
    output logic [COMMIT_WIDTH-1:0]           commit_valid,
    output logic [COMMIT_WIDTH*REG_IDX_W-1:0] commit_rd,
    output logic [COMMIT_WIDTH*DATA-1:0]      commit_data,
    output logic                              exc_valid,
    output logic [ADDR-1:0]                   exc_pc,
    output logic [$clog2(ROB_DEPTH):0]        count
);

    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [CNT_W-1:0]     head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d, exc_q, exc_d;

    logic [ADDR-1:0] pc_q   [ROB_DEPTH];
    reg_idx_t        rd_q   [ROB_DEPTH];
    logic [DATA-1:0] data_q [ROB_DEPTH];

    logic [TAG_W-1:0]        head_idx, tail_idx, ret_idx, slot_idx;
    logic [COMMIT_WIDTH-1:0] commit_mask;
    logic [CNT_W-1:0]        retire_cnt;
    logic                    exc_head, flush_now, alloc_fire, wb_fire;

    assign head_idx   = head_q[TAG_W-1:0];
    assign tail_idx   = tail_q[TAG_W-1:0];
    assign alloc_ready = count_q < CNT_W'(ROB_DEPTH);
    assign alloc_fire = alloc_valid & alloc_ready;
    assign wb_fire    = wb_valid & valid_q[wb_tag];
    assign flush_now  = exc_head | flush_in;

    rob_commit_sel #(
        .DEPTH (ROB_DEPTH),
        .CW    (COMMIT_WIDTH),
        .TAG_W (TAG_W)
    ) u_commit_sel (
        .valid_i       (valid_q),
        .done_i        (done_q),
        .exc_i         (exc_q),
        .head_i        (head_idx),
        .commit_mask_o (commit_mask),
        .retire_cnt_o  (retire_cnt),
        .head_exc_o    (exc_head)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        done_d  = done_q;
        exc_d   = exc_q;
        ret_idx = head_idx;
        if (flush_now) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
            exc_d   = '0;
        end else begin
            if (wb_fire) begin
                done_d[wb_tag] = 1'b1;
                exc_d[wb_tag]  = wb_exc;
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                ret_idx = head_idx + TAG_W'(i);
                if (commit_mask[i]) valid_d[ret_idx] = 1'b0;
            end
            // Allocation is blocked when full, so the tail slot never collides with a retiring one.
            if (alloc_fire) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                exc_d[tail_idx]   = 1'b0;
            end
            head_d  = head_q + retire_cnt;
            tail_d  = tail_q + CNT_W'(alloc_fire);
            count_d = count_q + CNT_W'(alloc_fire) - retire_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire && !flush_now) begin
            pc_q[tail_idx] <= alloc_pc;
            rd_q[tail_idx] <= alloc_rd;
        end
        if (wb_fire && !flush_now) data_q[wb_tag] <= wb_data;
    end

    // Payload RAM is not reset, so every payload output is gated by its strobe.
    always_comb begin
        commit_rd   = '0;
        commit_data = '0;
        slot_idx    = head_idx;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            slot_idx = head_idx + TAG_W'(i);
            if (commit_mask[i]) begin
                commit_rd[i*REG_IDX_W +: REG_IDX_W] = rd_q[slot_idx];
                commit_data[i*DATA +: DATA]         = data_q[slot_idx];
            end
        end
    end

    assign commit_valid = commit_mask;
    assign exc_valid    = exc_head;
    assign exc_pc       = exc_head ? pc_q[head_idx] : '0;
    assign alloc_tag    = tail_idx;
    assign count        = count_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Randomized and directed bench for rob_multi_commit against an in-order queue model.
module tb_rob_multi_commit;

    localparam int DATA  = 32;
    localparam int ADDR  = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 2;

    logic              clk;
    logic              reset;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [ADDR-1:0]   alloc_pc;
    logic [4:0]        alloc_rd;
    logic [3:0]        alloc_tag;
    logic              wb_valid;
    logic [3:0]        wb_tag;
    logic [DATA-1:0]   wb_data;
    logic              wb_exc;
    logic              flush_in;
    logic [CW-1:0]     commit_valid;
    logic [CW*5-1:0]   commit_rd;
    logic [CW*DATA-1:0] commit_data;
    logic              exc_valid;
    logic [ADDR-1:0]   exc_pc;
    logic [4:0]        count;

    rob_multi_commit #(
        .DATA         (DATA),
        .ADDR         (ADDR),
        .ROB_DEPTH    (DEPTH),
        .COMMIT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_pc     (alloc_pc),
        .alloc_rd     (alloc_rd),
        .alloc_tag    (alloc_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .wb_exc       (wb_exc),
        .flush_in     (flush_in),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic [4:0]  rd;
        bit          done;
        bit          exc;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   mhead;
    int   errors;
    int   checks;

    logic [CW-1:0] obs_cv;
    logic [4:0]    obs_count;
    logic [3:0]    obs_tag;
    logic          obs_ready;
    logic          obs_exc;
    logic [31:0]   obs_pc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mhead = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model at the edge.
    task automatic step(input logic av, input logic [31:0] pc, input logic [4:0] rd,
                        input logic wv, input logic [3:0] wt, input logic [31:0] wd,
                        input logic we, input logic fl);
        int   sz;
        int   e_tag;
        int   e_n;
        bit   e_ready;
        bit   e_exc;
        ent_t ne;
        @(negedge clk);
        alloc_valid = av;
        alloc_pc    = pc;
        alloc_rd    = rd;
        wb_valid    = wv;
        wb_tag      = wt;
        wb_data     = wd;
        wb_exc      = we;
        flush_in    = fl;
        #1;
        sz      = mq.size();
        e_ready = (sz < DEPTH);
        e_tag   = (mhead + sz) % DEPTH;
        e_exc   = (sz > 0) && mq[0].done && mq[0].exc;
        e_n     = 0;
        for (int i = 0; i < CW; i++)
            if (e_n == i && i < sz && mq[i].done && !mq[i].exc) e_n++;
        chk("count", 64'(count), 64'(sz));
        chk("alloc_ready", 64'(alloc_ready), 64'(e_ready));
        chk("alloc_tag", 64'(alloc_tag), 64'(e_tag));
        chk("exc_valid", 64'(exc_valid), 64'(e_exc));
        chk("exc_pc", 64'(exc_pc), e_exc ? 64'(mq[0].pc) : 64'd0);
        chk("commit_valid", 64'(commit_valid), 64'((1 << e_n) - 1));
        for (int i = 0; i < e_n; i++) begin
            chk("commit_rd", 64'(commit_rd[i*5 +: 5]), 64'(mq[i].rd));
            chk("commit_data", 64'(commit_data[i*DATA +: DATA]), 64'(mq[i].data));
        end
        obs_cv    = commit_valid;
        obs_count = count;
        obs_tag   = alloc_tag;
        obs_ready = alloc_ready;
        obs_exc   = exc_valid;
        obs_pc    = exc_pc;
        @(posedge clk);
        if (e_exc || fl) begin
            model_clear();
        end else begin
            if (wv)
                foreach (mq[k])
                    if (mq[k].tag == int'(wt)) begin
                        mq[k].done = 1'b1;
                        mq[k].exc  = we;
                        mq[k].data = wd;
                    end
            repeat (e_n) void'(mq.pop_front());
            mhead = (mhead + e_n) % DEPTH;
            if (av && e_ready) begin
                ne.tag  = e_tag;
                ne.pc   = pc;
                ne.rd   = rd;
                ne.done = 1'b0;
                ne.exc  = 1'b0;
                ne.data = '0;
                mq.push_back(ne);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [4:0] rd);
        step(1'b1, pc, rd, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wb(input logic [3:0] t, input logic [31:0] d, input logic e);
        step(1'b0, 32'd0, 5'd0, 1'b1, t, d, e, 1'b0);
    endtask

    task automatic flush();
        step(1'b0, 32'd0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, "_ready"}, 64'(alloc_ready), 64'd1);
        chk({tagname, "_cv"}, 64'(commit_valid), 64'd0);
        chk({tagname, "_exc"}, 64'(exc_valid), 64'd0);
        chk({tagname, "_count"}, 64'(count), 64'd0);
        chk({tagname, "_exc_pc"}, 64'(exc_pc), 64'd0);
        chk({tagname, "_cdata"}, 64'(commit_data), 64'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        reset       = 1'b1;
        alloc_valid = 1'b1;
        wb_valid    = 1'b0;
        flush_in    = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        reset       = 1'b0;
        alloc_valid = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time budget");
        $fatal(1);
    end

    initial begin
        logic        av, wv, we, fl;
        logic [3:0]  wt;
        errors = 0;
        checks = 0;
        reset       = 1'b1;
        alloc_valid = 1'b0;
        alloc_pc    = '0;
        alloc_rd    = '0;
        wb_valid    = 1'b0;
        wb_tag      = '0;
        wb_data     = '0;
        wb_exc      = 1'b0;
        flush_in    = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        chk("rst_tag", 64'(alloc_tag), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill: tags 0..15, then full.
        for (int t = 0; t < 16; t++) begin
            alloc(32'h100 + 32'(t * 4), 5'(t));
            if (t == 0)  chk("fill_tag0", 64'(obs_tag), 64'd0);
            if (t == 15) chk("fill_tag15", 64'(obs_tag), 64'd15);
        end
        alloc(32'h200, 5'd1);
        chk("full_count", 64'(obs_count), 64'd16);
        chk("full_ready", 64'(obs_ready), 64'd0);
        flush();
        idle();
        chk("flush_count", 64'(obs_count), 64'd0);

        // Out-of-order writeback, prefix commit.
        for (int t = 0; t < 4; t++) alloc(32'h300 + 32'(t * 4), 5'(t + 10));
        wb(4'd3, 32'hD3, 1'b0);
        wb(4'd1, 32'hD1, 1'b0);
        wb(4'd0, 32'hD0, 1'b0);
        idle();
        chk("ooo_cv11", 64'(obs_cv), 64'd3);
        chk("ooo_count4", 64'(obs_count), 64'd4);
        wb(4'd2, 32'hD2, 1'b0);
        chk("ooo_count2", 64'(obs_count), 64'd2);
        chk("ooo_cv00", 64'(obs_cv), 64'd0);
        idle();
        chk("ooo_cv11b", 64'(obs_cv), 64'd3);
        idle();
        chk("ooo_empty", 64'(obs_count), 64'd0);

        // Move head to 15, then wrap.
        for (int t = 0; t < 11; t++) alloc(32'h400 + 32'(t * 4), 5'(t));
        for (int t = 0; t < 11; t++) wb(4'(4 + t), 32'h500 + 32'(t), 1'b0);
        idle();
        idle();
        chk("pre_wrap_tag", 64'(obs_tag), 64'd15);
        alloc(32'h600, 5'd21);
        chk("wrap_tag15", 64'(obs_tag), 64'd15);
        alloc(32'h604, 5'd22);
        chk("wrap_tag0", 64'(obs_tag), 64'd0);
        alloc(32'h608, 5'd23);
        chk("wrap_tag1", 64'(obs_tag), 64'd1);
        wb(4'd1, 32'hA1, 1'b0);
        wb(4'd0, 32'hA0, 1'b0);
        wb(4'd15, 32'hAF, 1'b0);
        idle();
        chk("wrap_cv11", 64'(obs_cv), 64'd3);
        idle();
        chk("wrap_cv01", 64'(obs_cv), 64'd1);
        idle();
        chk("wrap_count", 64'(obs_count), 64'd0);
        chk("wrap_head2", 64'(obs_tag), 64'd2);

        // Exception at head.
        flush();
        alloc(32'h1000, 5'd1);
        alloc(32'h1004, 5'd2);
        alloc(32'h1008, 5'd3);
        wb(4'd0, 32'hEE, 1'b1);
        idle();
        chk("exc_valid", 64'(obs_exc), 64'd1);
        chk("exc_pc", 64'(obs_pc), 64'h1000);
        chk("exc_cv", 64'(obs_cv), 64'd0);
        idle();
        chk("exc_count", 64'(obs_count), 64'd0);

        // Full buffer with two retiring and an allocation attempt.
        for (int t = 0; t < 16; t++) alloc(32'h2000 + 32'(t * 4), 5'(t));
        wb(4'd1, 32'hB1, 1'b0);
        wb(4'd0, 32'hB0, 1'b0);
        alloc(32'h3000, 5'd9);
        chk("fullc_cv", 64'(obs_cv), 64'd3);
        chk("fullc_ready", 64'(obs_ready), 64'd0);
        chk("fullc_count16", 64'(obs_count), 64'd16);
        idle();
        chk("fullc_count14", 64'(obs_count), 64'd14);
        chk("fullc_ready1", 64'(obs_ready), 64'd1);

        // Flush with concurrent writeback and allocation.
        flush();
        for (int t = 0; t < 5; t++) alloc(32'h4000 + 32'(t * 4), 5'(t));
        step(1'b1, 32'h5000, 5'd7, 1'b1, 4'd0, 32'hCC, 1'b0, 1'b1);
        idle();
        chk("fl_count", 64'(obs_count), 64'd0);
        chk("fl_tail", 64'(obs_tag), 64'd0);
        chk("fl_cv", 64'(obs_cv), 64'd0);

        // Randomized traffic with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) mid_reset();
            av = ($urandom_range(99) < 60);
            wv = ($urandom_range(99) < 70);
            we = ($urandom_range(99) < 4);
            fl = ($urandom_range(99) < 2);
            if (mq.size() > 0 && $urandom_range(9) < 8)
                wt = 4'(mq[$urandom_range(mq.size() - 1)].tag);
            else
                wt = 4'($urandom_range(15));
            step(av, $urandom, 5'($urandom), wv, wt, $urandom, we, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_multi_commit.md
ROB_MULTI_COMMIT -- requirements
Module: rob_multi_commit

Interface
REQ-001 SHALL have parameter DATA, default 32: result data width.
REQ-002 SHALL have parameter ADDR, default 32: PC width.
REQ-003 SHALL have parameter ROB_DEPTH, default 16: entry count; power of two, 4..64.
REQ-004 SHALL have parameter COMMIT_WIDTH, default 2: maximum retirements per cycle, 1..4.
REQ-005 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset; asynchronous, active-high.
- alloc_valid  in  1  allocate one entry.
- alloc_ready  out  1  entry available.
- alloc_pc  in  ADDR  instruction PC.
- alloc_rd  in  5  destination register.
- alloc_tag  out  $clog2(ROB_DEPTH)  tag of the entry being allocated.
- wb_valid  in  1  writeback strobe.
- wb_tag  in  $clog2(ROB_DEPTH)  writeback target.
- wb_data  in  DATA  result.
- wb_exc  in  1  instruction raised an exception.
- flush_in  in  1  external flush (branch mispredict).
- commit_valid  out  COMMIT_WIDTH  per-slot retire strobe.
- commit_rd  out  COMMIT_WIDTH*5  per-slot destination register.
- commit_data  out  COMMIT_WIDTH*DATA  per-slot result.
- exc_valid  out  1  head entry is excepting.
- exc_pc  out  ADDR  PC of excepting head entry.
- count  out  $clog2(ROB_DEPTH)+1  occupied entries.

Function
REQ-006 SHALL be a circular buffer with head/tail pointers carrying one extra wrap bit; full = indices equal, wrap bits differ.
REQ-007 SHALL assert alloc_ready iff registered count < ROB_DEPTH; entries freed by commit in the same cycle do not count as free.
REQ-008 SHALL drive alloc_tag = tail index; on alloc_valid && alloc_ready, write pc/rd, clear done/exc, and advance tail by 1 with wrap.
REQ-009 SHALL ignore alloc_valid while alloc_ready is low.
REQ-010 SHALL, on wb_valid to an occupied tag, set done, store wb_data and wb_exc at the edge; a writeback to an unoccupied tag SHALL be ignored.
REQ-011 SHALL combinationally drive commit_valid[i] for i = 0..COMMIT_WIDTH-1 iff entries head..head+i are all occupied, done, and free of exception (prefix rule, never a gap); commit_rd/commit_data carry entry head+i.
REQ-012 SHALL advance head by the number of asserted commit_valid bits at the edge, with wrap.
REQ-013 SHALL assert exc_valid iff the head entry is occupied, done and exc, and SHALL then drive exc_pc with that entry's PC; commit_valid SHALL be all-zero in that cycle.
REQ-014 SHALL, at the edge following exc_valid or flush_in, empty the buffer (head = tail = 0, count = 0) and SHALL discard any same-cycle allocation, writeback and commit.
REQ-015 SHALL update count = count + alloc − commits every cycle; simultaneous alloc and commit at full SHALL leave count = ROB_DEPTH − commits + 0 (alloc blocked).
REQ-016 SHALL make a writeback visible to commit no earlier than the cycle after wb_valid (no bypass).

Reset
REQ-017 SHALL, while reset is high, hold head = tail = 0, count = 0, all valid/done/exc bits at 0, and alloc_ready = 1, commit_valid = 0, exc_valid = 0; exc_pc and commit_data SHALL be 0.
REQ-018 SHALL discard any in-flight state when reset asserts mid-operation; payload RAM need not be reset.

Structure
REQ-019 SHALL obtain the register-index width (5) and the ROB tag typedef from the shared cpu config package.
REQ-020 SHALL place the prefix-commit logic (done/exc vector from head → commit_valid mask, retire count) in one sub-module, rob_commit_sel.

Verification
REQ-021 Reset then 16 allocs with no writeback -> tags 0..15, count=16, alloc_ready=0 on cycle 17.
REQ-022 Allocate 4, write back tags 0,1,3 -> next cycle commit_valid=2'b11, count 4→2; tag 2 written back -> tags 2,3 commit next cycle.
REQ-023 Head at index 15, allocate 3 (tags 15,0,1), write back all -> two commits then one, head wraps to 2.
REQ-024 Allocate 3, wb tag0 with wb_exc=1, pc=0x1000 -> exc_valid=1, exc_pc=0x1000, commit_valid=0, next cycle count=0.
REQ-025 Full buffer, 2 ready at head, alloc_valid=1 -> 2 commits, allocation refused, count=14, alloc_ready=1 next cycle.
REQ-026 flush_in with 5 entries while wb_valid and alloc_valid asserted -> next cycle count=0, head=tail=0, no commit.
